// File: rtl/sync_pkg.sv
// Shared types and helpers for the barrier sync controller: FSM states,
// barrier id type and the round-robin pending-core search.
package sync_pkg;

  localparam int unsigned SYNC_BARRIER_WIDTH_DFLT = 8;
  localparam int unsigned MAX_CORES               = 32;

  typedef logic [SYNC_BARRIER_WIDTH_DFLT-1:0] barrier_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    CHECK   = 2'd2,
    RELEASE = 2'd3
  } sync_state_e;

  // First set bit of pend at or after ptr, wrapping inside [0, n_cores).
  // Returns ptr when nothing is pending; callers gate on |pend.
  function automatic logic [4:0] rr_next_pending(
    input logic [MAX_CORES-1:0] pend,
    input logic [4:0]           ptr,
    input logic [5:0]           n_cores
  );
    logic [5:0] idx;
    logic       found;
    rr_next_pending = ptr;
    found           = 1'b0;
    for (int k = 0; k < MAX_CORES; k++) begin
      idx = {1'b0, ptr} + 6'(k);
      if (idx >= n_cores) idx = idx - n_cores;
      if (!found && (6'(k) < n_cores) && pend[idx[4:0]]) begin
        rr_next_pending = idx[4:0];
        found           = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sync_mask_mem.sv
// Participant mask table: 1R1W, registered read, read-old-data when a
// write and a read hit the same address in one cycle. Not reset.
module sync_mask_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_barrier_ctrl.sv
// Barrier responder: holds requesting cores until every participant of the
// candidate barrier id has arrived, then releases the group in one cycle.
//
//   state   | meaning
//   IDLE    | pick next pending core round-robin, issue mask read
//   LOOKUP  | mask read in flight, snapshot pending set
//   CHECK   | compare snapshot against mask, decide release or move on
//   RELEASE | core_ready pulses, released pending bits clear
module sync_barrier_ctrl
  import sync_pkg::*;
#(
  parameter int unsigned N_CORES            = 4,
  parameter int unsigned SYNC_BARRIER_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] core_barrier,
  input  logic [N_CORES-1:0]                    core_enable,
  output logic [N_CORES-1:0]                    core_ready,
  input  logic                                  cfg_write_enable,
  input  logic [SYNC_BARRIER_WIDTH-1:0]         cfg_barrier_id,
  input  logic [N_CORES-1:0]                    cfg_mask,
  output logic                                  error
);

  localparam int unsigned W     = SYNC_BARRIER_WIDTH;
  localparam int unsigned PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  sync_state_e        r_state, w_state_nxt;
  logic [N_CORES-1:0] r_pend_valid;
  logic [W-1:0]       r_pend_id [N_CORES];
  logic [N_CORES-1:0] r_snap_valid;
  logic [N_CORES-1:0] r_ready;
  logic               r_error;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_cand_idx;
  logic [W-1:0]       r_cand_id;

  logic [PTR_W-1:0]   w_cand_idx;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic [W-1:0]       w_cand_id;
  logic               w_rd_en;
  logic [N_CORES-1:0] w_rd_mask;
  logic [N_CORES-1:0] w_arrived;
  logic               w_complete;
  logic [N_CORES-1:0] w_clr;
  logic [N_CORES-1:0] w_busy;
  logic [N_CORES-1:0] w_set;
  logic [N_CORES-1:0] w_dup;

  sync_mask_mem #(
    .ADDR_W (W),
    .DATA_W (N_CORES)
  ) u_mask_mem (
    .clk       (clk),
    .i_wr_en   (cfg_write_enable),
    .i_wr_addr (cfg_barrier_id),
    .i_wr_data (cfg_mask),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_cand_id),
    .o_rd_data (w_rd_mask)
  );

  // A core being released this cycle may re-request without counting as a duplicate.
  always_comb begin
    w_clr  = (r_state == RELEASE) ? r_ready : '0;
    w_busy = r_pend_valid & ~w_clr;
    w_set  = core_enable & ~w_busy;
    w_dup  = core_enable & w_busy;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_valid <= '0;
      r_error      <= 1'b0;
    end else begin
      r_pend_valid <= w_busy | w_set;
      if (|w_dup) r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (w_set[i]) r_pend_id[i] <= core_barrier[W*i +: W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_arrived   = '0;
    w_cand_idx  = PTR_W'(rr_next_pending(MAX_CORES'(r_pend_valid), 5'(r_rr_ptr),
                                         6'(N_CORES)));
    w_cand_id   = r_pend_id[w_cand_idx];
    w_ptr_inc   = (r_cand_idx == PTR_W'(N_CORES - 1)) ? '0 : r_cand_idx + PTR_W'(1);
    for (int i = 0; i < N_CORES; i++) begin
      w_arrived[i] = r_snap_valid[i] && (r_pend_id[i] == r_cand_id);
    end
    w_complete  = ((w_rd_mask & ~w_arrived) == '0);
    case (r_state)
      IDLE: begin
        if (|r_pend_valid) begin
          w_rd_en     = 1'b1;
          w_state_nxt = LOOKUP;
        end
      end
      LOOKUP:  w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_complete ? RELEASE : IDLE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The snapshot taken in LOOKUP keeps requests arriving during LOOKUP/CHECK
  // out of the current evaluation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_ready      <= '0;
      r_cand_idx   <= '0;
      r_cand_id    <= '0;
      r_snap_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= '0;
      case (r_state)
        IDLE: begin
          if (|r_pend_valid) begin
            r_cand_idx <= w_cand_idx;
            r_cand_id  <= w_cand_id;
          end
        end
        LOOKUP: r_snap_valid <= r_pend_valid;
        CHECK: begin
          if (w_complete) r_ready  <= w_arrived;
          else            r_rr_ptr <= w_ptr_inc;
        end
        RELEASE: r_rr_ptr <= w_ptr_inc;
        default: ;
      endcase
    end
  end

  assign core_ready = r_ready;
  assign error      = r_error;

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Bench for sync_barrier_ctrl: directed scenarios plus randomized traffic
// against a request/group-level reference model.
module tb_sync_barrier_ctrl;
  import sync_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int LAT_MAX = 3 * N + 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] core_barrier;
  logic [N-1:0]   core_enable;
  logic [N-1:0]   core_ready;
  logic           cfg_write_enable;
  logic [W-1:0]   cfg_barrier_id;
  logic [N-1:0]   cfg_mask;
  logic           error;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] mdl_mask [256];

  always #5 clk = ~clk;

  sync_barrier_ctrl #(
    .N_CORES            (N),
    .SYNC_BARRIER_WIDTH (W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_barrier     (core_barrier),
    .core_enable      (core_enable),
    .core_ready       (core_ready),
    .cfg_write_enable (cfg_write_enable),
    .cfg_barrier_id   (cfg_barrier_id),
    .cfg_mask         (cfg_mask),
    .error            (error)
  );

  task automatic wr_mask(input int id, input logic [N-1:0] m);
    @(negedge clk);
    cfg_write_enable = 1'b1;
    cfg_barrier_id   = W'(id);
    cfg_mask         = m;
    @(negedge clk);
    cfg_write_enable = 1'b0;
    mdl_mask[id]     = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    core_enable = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_req(input int core, input int id);
    core_enable[core]        = 1'b1;
    core_barrier[core*W +: W] = W'(id);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (core_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0000", core_ready);
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL reset_error got=%b exp=0", error);
    end
  endtask

  task automatic test_single_group();
    logic [N-1:0] exp;
    wr_mask(5, 4'b0011);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      core_enable = '0;
      exp = (c == 5) ? 4'b0011 : 4'b0000;
      checks++;
      if (core_ready !== exp) begin
        failures++;
        $display("FAIL single_group c=%0d got=%b exp=%b", c, core_ready, exp);
      end
      if (c == 1) begin
        set_req(0, 5);
        set_req(1, 5);
      end
    end
  endtask

  task automatic test_split_arrival();
    int pulses;
    pulses = 0;
    wr_mask(5, 4'b0011);
    do_reset();
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      core_enable = '0;
      if (c >= 41 && c <= 56) begin
        if (core_ready !== 4'b0000) begin
          checks++;
          if (core_ready === 4'b0011) pulses++;
          else begin
            failures++;
            $display("FAIL split_pulse c=%0d got=%b exp=0011", c, core_ready);
          end
        end
      end else begin
        checks++;
        if (core_ready !== 4'b0000) begin
          failures++;
          $display("FAIL split_quiet c=%0d got=%b exp=0000", c, core_ready);
        end
      end
      if (c == 10) set_req(0, 5);
      if (c == 40) set_req(1, 5);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL split_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_two_groups();
    int p_lo, p_hi;
    p_lo = 0;
    p_hi = 0;
    wr_mask(1, 4'b0011);
    wr_mask(2, 4'b1100);
    do_reset();
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      core_enable = '0;
      if (c <= 20) begin
        checks++;
        if (core_ready !== 4'b0000) begin
          failures++;
          $display("FAIL groups_early c=%0d got=%b exp=0000", c, core_ready);
        end
      end else if (core_ready !== 4'b0000) begin
        checks++;
        if (core_ready === 4'b0011) p_lo++;
        else if (core_ready === 4'b1100) p_hi++;
        else begin
          failures++;
          $display("FAIL groups_mixed c=%0d got=%b exp=0011_or_1100", c, core_ready);
        end
      end
      if (c == 10) begin
        set_req(0, 1);
        set_req(2, 2);
      end
      if (c == 20) begin
        set_req(1, 1);
        set_req(3, 2);
      end
    end
    checks++;
    if (p_lo != 1 || p_hi != 1) begin
      failures++;
      $display("FAIL groups_count got=%0d/%0d exp=1/1", p_lo, p_hi);
    end
  endtask

  task automatic test_zero_mask_and_error();
    int           pulses;
    logic [N-1:0] exp;
    logic         exp_err;
    pulses = 0;
    wr_mask(9, 4'b0000);
    wr_mask(7, 4'b0011);
    do_reset();
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      core_enable = '0;
      exp_err = (c >= 14);
      checks++;
      if (error !== exp_err) begin
        failures++;
        $display("FAIL dup_error c=%0d got=%b exp=%b", c, error, exp_err);
      end
      if (c >= 31 && c <= 46) begin
        if (core_ready !== 4'b0000) begin
          checks++;
          if (core_ready === 4'b0011) pulses++;
          else begin
            failures++;
            $display("FAIL dup_release c=%0d got=%b exp=0011", c, core_ready);
          end
        end
      end else begin
        exp = (c == 5) ? 4'b0100 : 4'b0000;
        checks++;
        if (core_ready !== exp) begin
          failures++;
          $display("FAIL zero_mask c=%0d got=%b exp=%b", c, core_ready, exp);
        end
      end
      if (c == 1)  set_req(2, 9);
      if (c == 10) set_req(0, 7);
      if (c == 13) set_req(0, 7);
      if (c == 30) set_req(1, 7);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL dup_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    wr_mask(5, 4'b0011);
    do_reset();
    for (int c = 0; c < 51; c++) begin
      @(negedge clk);
      core_enable = '0;
      checks++;
      if (error !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_error c=%0d got=%b exp=0", c, error);
      end
      if (c >= 31 && c <= 46) begin
        if (core_ready !== 4'b0000) begin
          checks++;
          if (core_ready === 4'b0011) pulses++;
          else begin
            failures++;
            $display("FAIL rst_mid_release c=%0d got=%b exp=0011", c, core_ready);
          end
        end
      end else begin
        checks++;
        if (core_ready !== 4'b0000) begin
          failures++;
          $display("FAIL rst_mid_quiet c=%0d got=%b exp=0000", c, core_ready);
        end
      end
      reset = (c == 8) ? 1'b0 : 1'b1;
      if (c == 2)  set_req(0, 5);
      if (c == 12) set_req(1, 5);
      if (c == 30) set_req(0, 5);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL rst_mid_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_collision();
    int           pulses;
    logic [N-1:0] exp;
    pulses = 0;
    wr_mask(3, 4'b0010);
    do_reset();
    for (int c = 0; c < 71; c++) begin
      @(negedge clk);
      core_enable      = '0;
      cfg_write_enable = 1'b0;
      if (c >= 31 && c <= 46) begin
        if (core_ready !== 4'b0000) begin
          checks++;
          if (core_ready === 4'b0110) pulses++;
          else begin
            failures++;
            $display("FAIL coll_second c=%0d got=%b exp=0110", c, core_ready);
          end
        end
      end else begin
        exp = (c == 5) ? 4'b0010 : 4'b0000;
        checks++;
        if (core_ready !== exp) begin
          failures++;
          $display("FAIL coll_first c=%0d got=%b exp=%b", c, core_ready, exp);
        end
      end
      if (c == 1) set_req(1, 3);
      if (c == 2) begin
        cfg_write_enable = 1'b1;
        cfg_barrier_id   = 8'd3;
        cfg_mask         = 4'b0110;
        mdl_mask[3]      = 4'b0110;
      end
      if (c == 10) set_req(1, 3);
      if (c == 30) set_req(2, 3);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL coll_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_random();
    bit           m_pend [N];
    int           m_id   [N];
    int           m_ecyc [N];
    bit           m_err;
    logic [N-1:0] pulse, exp, members;
    int           x, last;
    bit           cmpl;
    for (int id = 0; id < 8; id++) wr_mask(id, N'($urandom_range(0, 15)));
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_id[i]   = 0;
        m_ecyc[i] = 0;
      end
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        core_enable = '0;
        checks++;
        if (error !== m_err) begin
          failures++;
          $display("FAIL rand_error ep=%0d c=%0d got=%b exp=%b", ep, c, error, m_err);
        end
        pulse = core_ready;
        if (pulse !== '0) begin
          x = 0;
          for (int i = N - 1; i >= 0; i--) if (pulse[i] === 1'b1) x = m_id[i];
          for (int i = 0; i < N; i++)
            exp[i] = m_pend[i] && (m_id[i] == x) && (m_ecyc[i] <= c - 3);
          checks++;
          if (pulse !== exp) begin
            failures++;
            $display("FAIL rand_release ep=%0d c=%0d id=%0d got=%b exp=%b", ep, c, x, pulse, exp);
          end
          checks++;
          if ((mdl_mask[x] & ~pulse) !== '0) begin
            failures++;
            $display("FAIL rand_cover ep=%0d c=%0d id=%0d got=%b mask=%b", ep, c, x, pulse, mdl_mask[x]);
          end
          for (int i = 0; i < N; i++) if (pulse[i] === 1'b1) m_pend[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (m_pend[i]) begin
            x       = m_id[i];
            members = mdl_mask[x];
            cmpl    = 1'b1;
            last    = m_ecyc[i];
            for (int j = 0; j < N; j++) begin
              if (members[j]) begin
                if (!(m_pend[j] && m_id[j] == x)) cmpl = 1'b0;
                else if (m_ecyc[j] > last) last = m_ecyc[j];
              end
            end
            if (cmpl) begin
              checks++;
              if (c - last > LAT_MAX) begin
                failures++;
                $display("FAIL rand_latency ep=%0d core=%0d waited=%0d limit=%0d", ep, i, c - last, LAT_MAX);
                m_pend[i] = 1'b0;
              end
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 99) < 15) begin
            if (!m_pend[i] || $urandom_range(0, 9) == 0) begin
              x = int'($urandom_range(0, 7));
              set_req(i, x);
              if (m_pend[i]) m_err = 1'b1;
              else begin
                m_pend[i] = 1'b1;
                m_id[i]   = x;
                m_ecyc[i] = c;
              end
            end
          end
        end
      end
    end
    @(negedge clk);
    core_enable = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    core_enable      = '0;
    core_barrier     = '0;
    cfg_write_enable = 1'b0;
    cfg_barrier_id   = '0;
    cfg_mask         = '0;
    test_reset();
    test_single_group();
    test_split_arrival();
    test_two_groups();
    test_zero_mask_and_error();
    test_reset_mid_op();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_barrier_ctrl.md
Name: sync_barrier_ctrl

Overview:
Responder end of the sync interface for a multi-core distributed processor array.
- Each proc core raises a barrier request by pulsing its enable with a barrier id.
- The controller holds each core until every participating core has reached the same barrier id, then releases the whole group in the same cycle via per-core ready.
- The participant set for each barrier id comes from a writable mask table, loaded over a config port before the program runs.

Parameters:
N_CORES, 4, number of proc cores served.
SYNC_BARRIER_WIDTH, 8, barrier id width; the mask table holds 2**SYNC_BARRIER_WIDTH entries.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
core_barrier  input  N_CORES*SYNC_BARRIER_WIDTH  per-core barrier id; core i occupies bits [W*(i+1)-1 : W*i].
core_enable  input  N_CORES  per-core one-cycle barrier request pulse.
core_ready  output  N_CORES  per-core release pulse, one cycle, registered.
cfg_write_enable  input  1  mask table write strobe.
cfg_barrier_id  input  SYNC_BARRIER_WIDTH  mask table write address.
cfg_mask  input  N_CORES  participant mask to write; bit i = core i participates.
error  output  1  sticky flag: a core issued a request while it already had one pending.

Behaviour:
- Reset (reset == 0 at an edge):
  - pending_valid, core_ready, error, round-robin pointer and FSM state are all cleared; FSM goes to IDLE.
  - Mask table contents are not reset. They are undefined at power-up and persist across reset; software writes masks before use.
- Request capture: core_enable[i] at edge t sets pending_valid[i] and latches pending_id[i] at t+1.
- Duplicate requests: if core_enable[i] arrives while pending_valid[i] is set, the request is ignored, pending_id is unchanged, and error is set until reset.
- FSM states: IDLE, LOOKUP, CHECK, RELEASE.
  - IDLE: if any pending_valid bit is set, pick the candidate as the first pending core at or after rr_ptr (wrapping), latch cand_id, issue mask read at cand_id, go to LOOKUP. Otherwise stay in IDLE.
  - LOOKUP: mask read data returns (1-cycle read latency); go to CHECK.
  - CHECK:
    - arrived = pending_valid & (pending_id == cand_id), evaluated per core.
    - Complete when (mask & ~arrived) == 0. An all-zero mask is therefore complete on its own.
    - Complete: release_set = arrived; go to RELEASE.
    - Incomplete: rr_ptr = candidate+1 (mod N_CORES); go to IDLE.
  - RELEASE: core_ready = release_set for exactly one cycle; those pending_valid bits clear on the same edge; rr_ptr = candidate+1; go to IDLE.
- Cores pending on cand_id but absent from the mask are released with the group; they never block completion.
- Latency:
  - Simultaneous arrival of all participants with the FSM in IDLE and no other pending requests: core_ready asserts 4 cycles after the enable cycle.
  - General bound: 3*N_CORES+4 cycles after the last participant's enable.
  - core_ready never asserts before the last participant's enable.
- Same-cycle events:
  - core_enable[i] coinciding with core_ready[i]: the clear applies first, then the set, so the new request is captured.
  - core_enable[i] arriving during LOOKUP/CHECK is not included in the current evaluation. It is seen on a later pass.
- Config writes:
  - A write takes effect on the next LOOKUP.
  - A write and read to the same address in the same cycle returns old data.
  - A check already in flight uses the mask it has already read.
- Ids are compared over the full SYNC_BARRIER_WIDTH; there is no wrap or aliasing.

Decomposition:
- Package sync_pkg: FSM state enum (IDLE, LOOKUP, CHECK, RELEASE), typedef barrier_id_t (SYNC_BARRIER_WIDTH bits), and a helper function for the round-robin next-pending search.
- Sub-module sync_mask_mem: 1R1W, 2**SYNC_BARRIER_WIDTH x N_CORES, registered read with 1-cycle latency, read-old-data on address collision.

Test Plan:
1. mask[5]=4'b0011; core0 and core1 enable id 5 in the same cycle t with FSM idle -> core_ready=4'b0011 at t+4 for one cycle only; cores 2 and 3 stay 0.
2. mask[5]=4'b0011; core0 enables id 5 at cycle 10, core1 at cycle 40 -> core_ready stays 0 through cycle 40, then 4'b0011 pulses once within cycles 41..56.
3. mask[1]=4'b0011, mask[2]=4'b1100; cores 0,2 send ids 1,2 at cycle 10 and cores 1,3 send ids 1,2 at cycle 20 -> exactly two pulses, 4'b0011 and 4'b1100; no pulse ever mixes the pairs.
4. mask[9]=4'b0000; core2 enables id 9 -> core_ready=4'b0100 at +4. Core0 then enables twice, 3 cycles apart, with mask[7]=4'b0011 -> error=1 and stays 1; core0 is later released once when core1 arrives.
5. Reset mid-operation: mask[5]=4'b0011; core0 pending on id 5; drive reset=0 for one cycle; core1 then enables id 5 -> no release; core0 re-requests -> 4'b0011 released; error=0.
6. Collision: write mask[3]=4'b0110 in the same cycle the FSM reads mask[3] (old value 4'b0010), with core1 pending on id 3 -> core1 released alone; on core1's next id-3 request, completion requires core2.
